// File: rtl/wimax_pkg.sv
// Shared types and constants for the BPSK rate-1/2 OFDM transmit sequencer.
package wimax_pkg;

    localparam int unsigned BPSK_SYM_BITS  = 96;
    localparam int unsigned CONV_TAIL_BITS = 8;
    localparam int unsigned CODED_SYM_BITS = 2 * BPSK_SYM_BITS;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        TAIL,
        WAIT_IFFT
    } tx_state_t;

endpackage

// File: rtl/wimax_sym_counter.sv
// Bit-within-symbol and symbols-remaining counters with the data limit,
// last-symbol and symbol-full flags the sequencer FSM steers on.
module wimax_sym_counter
    import wimax_pkg::*;
#(
    parameter int unsigned SYM_BITS  = BPSK_SYM_BITS,
    parameter int unsigned TAIL_BITS = CONV_TAIL_BITS,
    parameter int unsigned LEN_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [LEN_W-1:0] len,
    input  logic             inc,
    input  logic             sym_next,
    output logic             last_c,
    output logic             limit_c,
    output logic             full_c
);

    localparam int unsigned CNT_W = $clog2(SYM_BITS + 1);
    localparam logic [CNT_W-1:0] FULL_IDX = CNT_W'(SYM_BITS - 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SYM_BITS - TAIL_BITS - 1);

    logic [CNT_W-1:0] bit_cnt;
    logic [LEN_W-1:0] sym_rem;

    // Load beats symbol advance beats increment; the limit compare is on the
    // pre-increment value so bit_cnt tops out at SYM_BITS and never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt <= '0;
            sym_rem <= '0;
        end else if (load) begin
            bit_cnt <= '0;
            sym_rem <= len;
        end else if (sym_next) begin
            bit_cnt <= '0;
            sym_rem <= sym_rem - LEN_W'(1);
        end else if (inc) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    assign last_c  = (sym_rem == LEN_W'(1));
    assign limit_c = (bit_cnt == (last_c ? LAST_IDX : FULL_IDX));
    assign full_c  = (bit_cnt == FULL_IDX);

endmodule

// File: rtl/wimax_tx_sequencer.sv
// Burst/symbol sequencer: gates MAC bits into OFDM symbols, reloads the
// randomizer per burst, appends coder tail bits and paces IFFT starts.
module wimax_tx_sequencer
    import wimax_pkg::*;
#(
    parameter int unsigned SYM_BITS  = BPSK_SYM_BITS,
    parameter int unsigned TAIL_BITS = CONV_TAIL_BITS,
    parameter int unsigned LEN_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             burst_start,
    input  logic [LEN_W-1:0] burst_len,
    input  logic             i,
    input  logic             i_valid,
    output logic             i_ready,
    output logic             rnd_init,
    output logic             enc_bit,
    output logic             enc_valid,
    output logic             enc_tail,
    output logic             enc_sym_end,
    input  logic             ifft_ready,
    output logic             ifft_start,
    output logic             busy,
    output logic             burst_done
);

    tx_state_t state, state_nx;

    logic cnt_load, cnt_inc, cnt_sym_next;
    logic last_c, limit_c, full_c;

    logic rnd_init_nx, enc_bit_nx, enc_valid_nx, enc_tail_nx, enc_sym_end_nx;
    logic ifft_start_nx, burst_done_nx;

    wimax_sym_counter #(
        .SYM_BITS  (SYM_BITS),
        .TAIL_BITS (TAIL_BITS),
        .LEN_W     (LEN_W)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .len      (burst_len),
        .inc      (cnt_inc),
        .sym_next (cnt_sym_next),
        .last_c   (last_c),
        .limit_c  (limit_c),
        .full_c   (full_c)
    );

    // Next-state, counter control and next registered output values.
    always_comb begin
        state_nx       = state;
        cnt_load       = 1'b0;
        cnt_inc        = 1'b0;
        cnt_sym_next   = 1'b0;
        rnd_init_nx    = 1'b0;
        enc_bit_nx     = 1'b0;
        enc_valid_nx   = 1'b0;
        enc_tail_nx    = 1'b0;
        enc_sym_end_nx = 1'b0;
        ifft_start_nx  = 1'b0;
        burst_done_nx  = 1'b0;

        case (state)
            IDLE: begin
                if (burst_start && (burst_len != '0)) begin
                    cnt_load    = 1'b1;
                    rnd_init_nx = 1'b1;
                    state_nx    = DATA;
                end
            end
            DATA: begin
                if (i_valid && i_ready) begin
                    cnt_inc      = 1'b1;
                    enc_bit_nx   = i;
                    enc_valid_nx = 1'b1;
                    if (limit_c) begin
                        if (last_c) begin
                            state_nx = TAIL;
                        end else begin
                            enc_sym_end_nx = 1'b1;
                            state_nx       = WAIT_IFFT;
                        end
                    end
                end
            end
            TAIL: begin
                cnt_inc      = 1'b1;
                enc_valid_nx = 1'b1;
                enc_tail_nx  = 1'b1;
                if (full_c) begin
                    enc_sym_end_nx = 1'b1;
                    state_nx       = WAIT_IFFT;
                end
            end
            WAIT_IFFT: begin
                if (ifft_ready) begin
                    cnt_sym_next  = 1'b1;
                    ifft_start_nx = 1'b1;
                    if (last_c) begin
                        burst_done_nx = 1'b1;
                        state_nx      = IDLE;
                    end else begin
                        state_nx = DATA;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // i_ready and busy follow the registered next state, never i_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            i_ready     <= 1'b0;
            busy        <= 1'b0;
            rnd_init    <= 1'b0;
            enc_bit     <= 1'b0;
            enc_valid   <= 1'b0;
            enc_tail    <= 1'b0;
            enc_sym_end <= 1'b0;
            ifft_start  <= 1'b0;
            burst_done  <= 1'b0;
        end else begin
            state       <= state_nx;
            i_ready     <= (state_nx == DATA);
            busy        <= (state_nx != IDLE);
            rnd_init    <= rnd_init_nx;
            enc_bit     <= enc_bit_nx;
            enc_valid   <= enc_valid_nx;
            enc_tail    <= enc_tail_nx;
            enc_sym_end <= enc_sym_end_nx;
            ifft_start  <= ifft_start_nx;
            burst_done  <= burst_done_nx;
        end
    end

endmodule

// File: doc/wimax_tx_sequencer.md
Name: wimax_tx_sequencer

Overview:
Burst/symbol sequencer for the BPSK rate-1/2 OFDM transmit chain. It sits between the MAC bit source and the randomizer, convolutional coder, channel mapper and IFFT pipeline.
- Gates the input bit stream into fixed-size OFDM symbols.
- Reloads the randomizer seed at burst start.
- Appends the zero tail bits that flush the convolutional coder on the last symbol.
- Sequences one IFFT start per symbol, honouring IFFT readiness.

Parameters:
SYM_BITS, 96, uncoded bits per OFDM symbol (BPSK 1/2: 12 bytes; coded output is 192 bits = 192 data subcarriers).
TAIL_BITS, 8, zero tail bits appended at the end of the last symbol of a burst; must be < SYM_BITS.
LEN_W, 8, width of the burst length field, in symbols.

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
burst_start  in  1  one-cycle request to start a burst; sampled only in IDLE
burst_len  in  LEN_W  number of OFDM symbols in the burst; sampled with burst_start
i  in  1  input data bit
i_valid  in  1  input bit valid
i_ready  out  1  sequencer accepts a bit this cycle
rnd_init  out  1  one-cycle pulse: randomizer reloads its seed
enc_bit  out  1  bit to randomizer/coder path
enc_valid  out  1  enc_bit valid
enc_tail  out  1  qualifies enc_bit as a tail bit; randomizer is bypassed while high
enc_sym_end  out  1  coincides with the last enc_valid of each symbol
ifft_ready  in  1  IFFT/mapper can accept a new symbol
ifft_start  out  1  one-cycle pulse: start IFFT on the symbol just mapped
busy  out  1  high in every state except IDLE
burst_done  out  1  one-cycle pulse when the final ifft_start is issued

Behaviour:
- All outputs are registered. Reset value of every output is 0; state goes to IDLE and all counters clear. Reset mid-burst abandons the burst without tail or ifft_start.
- States: IDLE, DATA, TAIL, WAIT_IFFT.
- IDLE:
  - burst_start=1 with burst_len!=0: latch sym_rem=burst_len, clear bit_cnt, pulse rnd_init on the next cycle, enter DATA.
  - burst_start with burst_len==0 is ignored.
  - burst_start outside IDLE is ignored.
- DATA:
  - i_ready=1. An accept is i_valid & i_ready.
  - Each accept drives enc_bit=i and enc_valid=1 on the next cycle (latency 1). bit_cnt increments.
  - Bubbles on i_valid produce bubbles on enc_valid; there is no timeout.
  - Data limit per symbol is SYM_BITS, or SYM_BITS-TAIL_BITS when sym_rem==1.
  - Accept that reaches the limit on the last symbol: go to TAIL; i_ready drops the following cycle.
  - Accept that reaches SYM_BITS on a non-last symbol: that output carries enc_sym_end=1; go to WAIT_IFFT.
- TAIL:
  - i_ready=0. Emit TAIL_BITS consecutive cycles of enc_bit=0, enc_valid=1, enc_tail=1; no stalls.
  - The last tail bit carries enc_sym_end=1. Then go to WAIT_IFFT.
- WAIT_IFFT:
  - i_ready=0. On the first cycle with ifft_ready=1: pulse ifft_start, decrement sym_rem, clear bit_cnt.
  - If sym_rem was 1: pulse burst_done together with ifft_start and return to IDLE.
  - Otherwise return to DATA.
  - If ifft_ready is already high on entry, ifft_start fires on the first WAIT_IFFT cycle.
- rnd_init is pulsed once per burst only (not per symbol).
- Total bits accepted per burst = burst_len*SYM_BITS - TAIL_BITS.
- Widths:
  - bit_cnt is $clog2(SYM_BITS+1) bits; it never wraps, because the limit compare precedes increment.
  - sym_rem is LEN_W bits; burst_len=2^LEN_W-1 must work.
- i_ready is a registered function of state, so i_valid never combinationally affects i_ready.

Decomposition:
- Shared package wimax_pkg: state enum (IDLE/DATA/TAIL/WAIT_IFFT), BPSK_SYM_BITS=96, CONV_TAIL_BITS=8, CODED_SYM_BITS=192.
- One natural sub-module: wimax_sym_counter, holding bit_cnt/sym_rem with limit, last and terminal flags. The FSM stays in the top.

Test Plan:
1. burst_len=1, 88 bits streamed with i_valid=1, ifft_ready=1 → expected response:
   - rnd_init 1 cycle after burst_start.
   - 88 enc_valid bits equal to input, then 8 zero bits with enc_tail=1.
   - enc_sym_end on the 96th.
   - ifft_start and burst_done together on the next cycle; busy falls.
2. burst_len=3, continuous input → expected response:
   - Exactly 280 bits accepted.
   - enc_sym_end on enc_valid #96, #192 and #288.
   - 3 ifft_start pulses; enc_tail only on outputs 281-288; rnd_init once.
3. burst_len=2, ifft_ready held low for 20 cycles after symbol 1 → i_ready=0 and no enc_valid throughout the hold; ifft_start exactly one cycle after ifft_ready rises; symbol 2 then proceeds.
4. i_valid toggling 1010… in DATA → enc_valid mirrors accepts with 1-cycle latency; bit_cnt is unaffected by the gaps; the tail is still emitted back-to-back.
5. burst_start while busy, and burst_start with burst_len=0 in IDLE → no state change, no rnd_init, no extra accepts.
6. reset asserted at bit 40 of symbol 2 → the cycle after, all outputs are 0 and the FSM is in IDLE; a fresh burst_len=1 then completes normally.
